// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: CPU pushes bytes into a 4-entry FIFO at
// BASE_ADDR, reads status at BASE_ADDR+1, and frames go out 8N1 on tx.
module mmio_uart_tx #(
    parameter logic [7:0] BASE_ADDR    = 8'h7E,
    parameter int         CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] address,
    input  logic [7:0] data_in,
    input  logic       write,
    output logic [7:0] data_out,
    output logic       sel,
    output logic       tx,
    output logic       busy
);

    localparam logic [7:0] STAT_ADDR = BASE_ADDR + 8'd1;
    localparam logic [7:0] TMAX      = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Transmit engine state
    state_t      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;

    // FIFO state
    logic [7:0]  mem_q [4];
    logic [7:0]  mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        ovf_q, ovf_d;

    // Decoded strobes and FIFO flags
    logic        fifo_empty;
    logic        fifo_full;
    logic [7:0]  head;
    logic        push_req;
    logic        clr_req;
    logic        push_ok;
    logic        ovf_set;
    logic        pop;
    logic        timer_end;

    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == 3'd4);
    assign head       = mem_q[rd_ptr_q];
    assign push_req   = write && (address == BASE_ADDR);
    assign clr_req    = write && (address == STAT_ADDR);
    assign timer_end  = (timer_q == TMAX);

    // Transmit FSM: next state, serial output and the FIFO pop request.
    // A pop happens either from IDLE or at the last cycle of STOP, so that
    // queued bytes go out back-to-back with no idle bit between frames.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                pop = !fifo_empty;
            end
            S_START: begin
                if (timer_end) begin
                    timer_d   = 8'd0;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    state_d   = S_DATA;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_DATA: begin
                if (timer_end) begin
                    timer_d = 8'd0;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_STOP: begin
                if (timer_end) begin
                    timer_d = 8'd0;
                    if (fifo_empty) begin
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        pop = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Frame launch shared by IDLE and the back-to-back path out of STOP
        if (pop) begin
            shift_d   = head;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            timer_d   = 8'd0;
            bit_idx_d = 3'd0;
            state_d   = S_START;
        end
    end

    // FIFO bookkeeping: a pop in the same cycle frees the slot a full-FIFO
    // push needs, and an overflow set beats a simultaneous clear.
    always_comb begin
        push_ok  = push_req && (!fifo_full || pop);
        ovf_set  = push_req && fifo_full && !pop;

        wr_ptr_d = push_ok ? (wr_ptr_q + 2'd1) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + 2'd1) : rd_ptr_q;
        count_d  = count_q + {2'b00, push_ok} - {2'b00, pop};

        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (clr_req) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_in;
        end
    end

    // CPU read mux: side-effect free, combinational.
    always_comb begin
        sel      = (address == BASE_ADDR) || (address == STAT_ADDR);
        data_out = 8'h00;
        if (address == BASE_ADDR) begin
            data_out = fifo_empty ? 8'h00 : head;
        end else if (address == STAT_ADDR) begin
            data_out = {4'b0000, ovf_q, busy_q, fifo_empty, fifo_full};
        end
    end

    // Control and shift state, cleared asynchronously so a reset mid-frame
    // returns tx high at once and discards anything queued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            timer_q   <= 8'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            wr_ptr_q  <= 2'd0;
            rd_ptr_q  <= 2'd0;
            count_q   <= 3'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // FIFO storage; contents are only meaningful under the count, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a queue-based reference model of the
// FIFO and frame timing is compared against the DUT every cycle, with a few
// hand-computed literal expectations on top.
module tb_mmio_uart_tx;

    localparam logic [7:0] BASE  = 8'h7E;
    localparam logic [7:0] STAT  = 8'h7F;
    localparam int         CPB   = 4;
    localparam int         FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] address = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       write = 1'b0;
    logic [7:0] data_out;
    logic       sel;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .data_in  (data_in),
        .write    (write),
        .data_out (data_out),
        .sel      (sel),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model: queue of pending bytes, position inside current frame
    logic [7:0] mq[$];
    int         fpos  = -1;
    logic [7:0] fbyte = 8'h00;
    bit         movf  = 1'b0;

    always @(posedge clk or negedge reset) begin : model_upd
        int sz;
        bit popn;
        if (!reset) begin
            mq.delete();
            fpos  = -1;
            fbyte = 8'h00;
            movf  = 1'b0;
        end else begin
            sz   = mq.size();
            popn = (sz > 0) && (fpos < 0 || fpos == FRAME - 1);
            if (popn) begin
                fbyte = mq.pop_front();
                fpos  = 0;
            end else if (fpos >= 0) begin
                fpos++;
                if (fpos == FRAME) fpos = -1;
            end
            if (write && address == BASE) begin
                if (sz < 4 || popn) mq.push_back(data_in);
                else movf = 1'b1;
            end else if (write && address == STAT) begin
                movf = 1'b0;
            end
        end
    end

    function automatic logic exp_tx();
        int b;
        if (fpos < 0) return 1'b1;
        b = fpos / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return fbyte[3'(b - 1)];
    endfunction

    function automatic logic [7:0] exp_dout();
        if (address == BASE) return (mq.size() > 0) ? mq[0] : 8'h00;
        if (address == STAT)
            return {4'b0000, movf, (fpos >= 0), (mq.size() == 0), (mq.size() == 4)};
        return 8'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx", 32'(tx), 32'(exp_tx()));
            chk("busy", 32'(busy), 32'(fpos >= 0));
            chk("sel", 32'(sel), 32'((address == BASE) || (address == STAT)));
            chk("data_out", 32'(data_out), 32'(exp_dout()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        write   = 1'b1;
        cyc();
        write   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || fpos >= 0 || mq.size() != 0) && n < 2000) begin
            cyc();
            n++;
        end
        chk("drain_timeout", 32'(n < 2000), 32'd1);
        cyc();
    endtask

    task automatic status_is(input string name, input logic [7:0] v);
        address = STAT;
        #1;
        chk(name, 32'(data_out), 32'(v));
    endtask

    initial begin
        logic [9:0] pat;
        int n;
        int r;

        // Reset held: idle line, empty FIFO status
        #2 reset = 1'b0;
        #1 address = STAT;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_status", 32'(data_out), 32'h02);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        chk_en = 1'b1;
        cyc();

        // Reads with no side effects, empty FIFO and unmapped address
        address = BASE;
        #1;
        chk("rd_empty_data", 32'(data_out), 32'h00);
        chk("rd_empty_sel", 32'(sel), 32'd1);
        address = 8'h10;
        #1;
        chk("rd_other_sel", 32'(sel), 32'd0);
        chk("rd_other_data", 32'(data_out), 32'h00);
        cyc();

        // Single frame 0x55: start, 10101010 LSB first, stop, 4 cycles each
        pat = 10'b1010101010;
        do_write(BASE, 8'h55);
        chk("f55_pre_tx", 32'(tx), 32'd1);
        chk("f55_pre_busy", 32'(busy), 32'd0);
        for (int i = 0; i < FRAME; i++) begin
            cyc();
            chk("f55_tx", 32'(tx), 32'(pat[i / CPB]));
            chk("f55_busy", 32'(busy), 32'd1);
        end
        cyc();
        chk("f55_end_busy", 32'(busy), 32'd0);
        chk("f55_end_tx", 32'(tx), 32'd1);
        wait_idle();

        // Five bytes from idle: one popped at once, four fill the FIFO
        do_write(BASE, 8'hA1);
        do_write(BASE, 8'hB2);
        do_write(BASE, 8'hC3);
        do_write(BASE, 8'hD4);
        do_write(BASE, 8'hE5);
        status_is("burst_status", 8'h05);
        n = 0;
        while (busy && n < 400) begin
            n++;
            cyc();
        end
        chk("burst_busy_len", 32'(n), 32'd197);
        status_is("burst_end_status", 8'h02);
        wait_idle();

        // Overflow: five pushes during a frame, fifth dropped, then clear
        do_write(BASE, 8'h11);
        cyc();
        cyc();
        do_write(BASE, 8'h21);
        do_write(BASE, 8'h22);
        do_write(BASE, 8'h23);
        do_write(BASE, 8'h24);
        do_write(BASE, 8'h25);
        status_is("ovf_status", 8'h0D);
        address = BASE;
        #1;
        chk("ovf_head", 32'(data_out), 32'h21);
        do_write(STAT, 8'($urandom));
        status_is("ovf_cleared", 8'h05);
        wait_idle();

        // Push into a full FIFO on the same edge the FSM pops
        do_write(BASE, 8'h3C);
        do_write(BASE, 8'h41);
        do_write(BASE, 8'h42);
        do_write(BASE, 8'h43);
        do_write(BASE, 8'h44);
        status_is("full_pre", 8'h05);
        n = 0;
        while (fpos != FRAME - 1 && n < 100) begin
            cyc();
            n++;
        end
        chk("full_align_timeout", 32'(n < 100), 32'd1);
        do_write(BASE, 8'h99);
        status_is("full_pushpop", 8'h05);
        wait_idle();

        // Asynchronous reset 13 cycles into a frame with a byte queued
        do_write(BASE, 8'h96);
        do_write(BASE, 8'h5A);
        repeat (12) cyc();
        #2 reset = 1'b0;
        #1;
        chk("arst_tx", 32'(tx), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        status_is("arst_status", 8'h02);
        cyc();
        cyc();
        #2 reset = 1'b1;
        n = 0;
        repeat (100) begin
            cyc();
            if (!tx || busy) n++;
        end
        chk("arst_no_frame", 32'(n), 32'd0);

        // Randomized traffic with one asynchronous reset in the middle
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 9);
            write = ($urandom_range(0, 99) < 35);
            if (r <= 4 || r >= 8) address = BASE;
            else if (r == 5) address = STAT;
            else address = 8'($urandom);
            data_in = 8'($urandom);
            if (i == 1300) begin
                #($urandom_range(1, 3));
                reset = 1'b0;
            end
            if (i == 1302) begin
                #2;
                reset = 1'b1;
            end
            cyc();
        end
        write = 1'b0;
        address = 8'h00;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
